// File: rtl/wb_initiator_pkg.sv
// wb_initiator_pkg: shared command record and FSM state type for the Wishbone initiator
package wb_initiator_pkg;

    localparam int CMD_ADR_W = 32;
    localparam int CMD_DAT_W = 32;

    typedef struct packed {
        logic                   we;
        logic [CMD_ADR_W-1:0]   adr;
        logic [CMD_DAT_W-1:0]   dat;
        logic [CMD_DAT_W/8-1:0] sel;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

endpackage

// File: rtl/wb_if.sv
// wb_if: classic single-cycle Wishbone bus bundle
interface wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic                    ack;
    logic                    err;

    modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
    modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/wb_cmd_fifo.sv
// wb_cmd_fifo: synchronous FIFO for buffered commands, no bypass path
module wb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic             push_ok, pop_ok;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rp];

    // storage array carries no reset; only written on accepted pushes
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= push_ok ? wp + 1'b1 : wp;
            rp  <= pop_ok ? rp + 1'b1 : rp;
            cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: runs buffered valid/ready commands as single Wishbone cycles with timeout
module wb_cmd_initiator
    import wb_initiator_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = CMD_ADR_W,
    parameter int WB_DATA_WIDTH  = CMD_DAT_W,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [WB_ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [WB_DATA_WIDTH-1:0]   cmd_dat,
    input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WB_DATA_WIDTH-1:0]   rsp_dat,
    output logic                       rsp_err,
    output logic                       rsp_timeout,
    wb_if.master                       m
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    state_t        state;
    cmd_t          push_cmd, head;
    logic          full, empty, pop;
    logic [CW-1:0] tcnt;

    assign push_cmd  = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
    assign cmd_ready = !full;
    assign pop       = state == IDLE && !empty;

    wb_cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (cmd_valid),
        .pop  (pop),
        .din  (push_cmd),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    // command sequencer: issue one bus cycle, wait for ACK/ERR/timeout, hold the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            m.cyc       <= 1'b0;
            m.stb       <= 1'b0;
            m.we        <= 1'b0;
            m.adr       <= '0;
            m.dat_w     <= '0;
            m.sel       <= '0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    m.we    <= head.we;
                    m.adr   <= head.adr;
                    m.dat_w <= head.dat;
                    m.sel   <= head.sel;
                    m.cyc   <= 1'b1;
                    m.stb   <= 1'b1;
                    tcnt    <= '0;
                    state   <= BUS;
                end
                BUS: begin
                    // a slave answer in the expiry cycle still counts as an answer
                    if (m.ack || m.err || tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        m.cyc       <= 1'b0;
                        m.stb       <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= m.err || !m.ack;
                        rsp_timeout <= !m.ack && !m.err;
                        rsp_dat     <= (m.ack && !m.err && !m.we) ? m.dat_r : '0;
                        state       <= RSP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RSP: if (rsp_ready) begin
                    rsp_valid   <= 1'b0;
                    rsp_err     <= 1'b0;
                    rsp_timeout <= 1'b0;
                    rsp_dat     <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
